// File: rtl/rnm_pkg.sv
// rnm_pkg: shared state type, widths and helpers for rare_node_activity_monitor.
package rnm_pkg;

    // Monitor FSM states; the encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALERT = 2'd2
    } rnm_state_e;

    localparam int unsigned TOTAL_W = 16;   // alert_total width
    localparam int unsigned TS_W    = 32;   // timestamp width

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TOTAL_W-1:0] sat_inc_total(input logic [TOTAL_W-1:0] value);
        if (value == {TOTAL_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/rnm_edge_sync.sv
// rnm_edge_sync: two-stage sampling of the monitored node and 0->1 detection.
// act_o is high for one cycle after a rise has been captured in s1, so a level
// held high produces exactly one activation.
module rnm_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic node_i,
    output logic act_o
);

    logic s1_q;
    logic s2_q;

    // Shift the node through s1 then s2 every clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= node_i;
            s2_q <= s1_q;
        end
    end

    assign act_o = s1_q & ~s2_q;

endmodule

// File: rtl/rare_node_activity_monitor.sv
// rare_node_activity_monitor: counts rising edges of node I15645 over fixed
// windows of WIN_LEN cycles and raises a held alarm when a closing window
// reaches THRESH activations. The alarm stays up until alarm_ack.
// Optional feature macro: RNM_TIMESTAMP_EN adds a free-running cycle counter
// and the alarm_ts output captured on every ALERT entry.
//
// Windowing runs on every edge with mon_en=1; the edge that leaves IDLE is the
// win_cnt=0 edge of the first window. dbg_state exports the FSM state.
module rare_node_activity_monitor
    import rnm_pkg::*;
#(
    parameter int unsigned WIN_LEN = 256,
    parameter int unsigned THRESH  = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               I1470,
    input  logic               I1477,
    input  logic               I15645,
    input  logic               mon_en,
    input  logic               alarm_ack,
    output logic               alarm,
    output logic               win_done,
    output logic [CNT_W-1:0]   win_count,
    output logic [TOTAL_W-1:0] alert_total,
`ifdef RNM_TIMESTAMP_EN
    output logic [TS_W-1:0]    alarm_ts,
`endif
    output logic [1:0]         dbg_state
);

    localparam int unsigned      WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    rnm_state_e         state_q;
    logic               alarm_q;
    logic               win_done_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [CNT_W-1:0]   act_cnt_q;
    logic [CNT_W-1:0]   act_cnt_d;
    logic [CNT_W-1:0]   win_count_q;
    logic [TOTAL_W-1:0] alert_total_q;
    logic               act;
    logic               win_close;
    logic               hit;

    rnm_edge_sync u_edge_sync (
        .clk_i  (I1470),
        .rst_ni (I1477),
        .node_i (I15645),
        .act_o  (act)
    );

    // Running count including this cycle's activation, saturated at all-ones.
    always_comb begin
        act_cnt_d = act_cnt_q;
        if (act && (act_cnt_q != CNT_MAX)) begin
            act_cnt_d = act_cnt_q + 1'b1;
        end
    end

    // An activation on the closing edge still belongs to the closing window.
    assign win_close = mon_en && (win_cnt_q == WIN_LAST);
    assign hit       = win_close && (act_cnt_d >= THRESH_C);

    // Monitor FSM with the alarm level registered alongside the state.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mon_en) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!mon_en) begin
                        state_q <= IDLE;
                    end else if (hit) begin
                        state_q <= ALERT;
                        alarm_q <= 1'b1;
                    end
                end
                ALERT: begin
                    // A fresh hit on the ack edge keeps the alarm raised.
                    if (alarm_ack && !hit) begin
                        state_q <= mon_en ? ARMED : IDLE;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    // Window position, activation count, window result and alert tally.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            win_cnt_q     <= '0;
            act_cnt_q     <= '0;
            win_count_q   <= '0;
            win_done_q    <= 1'b0;
            alert_total_q <= '0;
        end else begin
            win_done_q <= 1'b0;
            if (!mon_en) begin
                win_cnt_q <= '0;
                act_cnt_q <= '0;
            end else if (win_close) begin
                win_cnt_q   <= '0;
                act_cnt_q   <= '0;
                win_count_q <= act_cnt_d;
                win_done_q  <= 1'b1;
                if (hit) begin
                    alert_total_q <= sat_inc_total(alert_total_q);
                end
            end else begin
                win_cnt_q <= win_cnt_q + 1'b1;
                act_cnt_q <= act_cnt_d;
            end
        end
    end

`ifdef RNM_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] alarm_ts_q;

    // Free-running cycle counter; snapshot it only on ARMED->ALERT entry.
    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            ts_cnt_q   <= '0;
            alarm_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if ((state_q == ARMED) && hit) begin
                alarm_ts_q <= ts_cnt_q;
            end
        end
    end

    assign alarm_ts = alarm_ts_q;
`endif

    assign alarm       = alarm_q;
    assign win_done    = win_done_q;
    assign win_count   = win_count_q;
    assign alert_total = alert_total_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/rare_node_activity_monitor.md
# rare_node_activity_monitor

Downstream consumer of a rare-switching internal node in the benchmark subcircuits; here the node is I15645. The block samples the node every clock, counts rising-edge activations over fixed windows and raises a held alarm when a window reaches a threshold. An activation burst on a normally quiet node is the trigger signature the detection flow flags. The alarm is a level that stays asserted until acknowledged, so a slow host can collect it.

## Interface
- WIN_LEN, 256: window length in cycles, ≥2.
- THRESH, 4: activations per window that raise an alert, 1..2^CNT_W-1.
- CNT_W, 8: activation counter width.
- I1470  in  1  clock; all flops rising-edge.
- I1477  in  1  reset, asynchronous, active-low.
- I15645  in  1  monitored node, synchronous to I1470.
- mon_en  in  1  monitoring enable.
- alarm_ack  in  1  alarm acknowledge; meaningful only while alarm=1.
- alarm  out  1  alert level, held until acknowledged.
- win_done  out  1  one-cycle pulse at each window close.
- win_count  out  CNT_W  activation count of the last closed window.
- alert_total  out  16  number of threshold hits, saturating at 0xFFFF.

## Operation
- Sampling:
  - s1 <= I15645 and s2 <= s1 on every edge.
  - act = s1 & ~s2, meaning a 0→1 transition.
  - A level held high counts once.
- FSM states:
  - IDLE: the state after reset.
  - ARMED: entered from IDLE when mon_en=1.
  - ALERT: entered from ARMED when a window closes with count ≥ THRESH.
  - ALERT→ARMED on alarm_ack when mon_en=1; ALERT→IDLE on alarm_ack when mon_en=0.
  - ARMED→IDLE when mon_en=0.
- Windowing runs in ARMED, and in ALERT while mon_en=1:
  - win_cnt runs 0..WIN_LEN-1 and wraps.
  - act_cnt increments on act and saturates at 2^CNT_W-1.
- Window close, i.e. the edge with win_cnt=WIN_LEN-1:
  - closing_count = act_cnt + act, saturated. An activation on the last cycle belongs to the closing window.
  - win_count <= closing_count; act_cnt <= 0; win_done pulses.
  - If closing_count ≥ THRESH: alert_total increments (saturating); in ARMED, go to ALERT.
  - In ALERT, alarm simply stays high.
- mon_en=0:
  - win_cnt and act_cnt clear.
  - win_count and alert_total hold.
  - The ALERT state persists until acknowledged.
- Reset values: alarm=0, win_done=0, win_count=0, alert_total=0; all internal counters 0; state IDLE.

## Timing
- Detection latency: a node rise ahead of edge k is captured in s1 at k and counted at edge k+1.
- alarm and win_done are registered at the window-close edge. Both are visible in the following cycle.
- alarm_ack at edge e with alarm=1 → alarm=0 after e.
- Ack and a new threshold hit on the same edge: the hit wins; alarm stays 1 and alert_total increments.
- alarm_ack while alarm=0 is ignored.
- Reset is asynchronous. Asserting I1477 mid-window clears everything immediately, including a pending alarm. After release, the first window starts at win_cnt=0 on the first edge with mon_en=1.

## Configuration
- RNM_TIMESTAMP_EN defined:
  - Adds a 32-bit free-running cycle counter, reset to 0 and wrapping.
  - Adds output alarm_ts (32 bits), loaded with the counter value at the edge of ALERT entry and held until the next ALERT entry.
- RNM_TIMESTAMP_EN undefined: the counter and the alarm_ts port are absent. All other behaviour is identical.

## Structure
- Package rnm_pkg holds:
  - The state enum (IDLE, ARMED, ALERT).
  - The alert_total width constant (16) and timestamp width constant (32).
  - A saturating-increment function.
- Sub-module rnm_edge_sync holds the s1/s2 sampling and act generation.
- The top holds the FSM, counters and outputs.

## Test plan
- Reset, then mon_en=1 with the node held 0 for 3 windows (WIN_LEN=16, THRESH=3): win_done pulses every 16 cycles; win_count=0; alarm=0.
- Three 1-cycle node pulses in a window: alarm=1 and win_count=3 the cycle after the close. alert_total=1. alarm_ack → alarm=0 next cycle; state ARMED.
- Two pulses mid-window plus one pulse timed so act is high on win_cnt=15: win_count=3 and alarm=1. The next window's count is 0.
- Node held high for a full window: win_count=1, no alarm. Separately, 300 pulses with CNT_W=8 and WIN_LEN=1024: win_count=255 (saturated).
- alarm_ack on the same edge as a second threshold hit: alarm stays 1 and alert_total goes 1→2. Assert I1477 mid-window: all outputs 0 immediately.
- With RNM_TIMESTAMP_EN: first alert at cycle N gives alarm_ts=N. A second alert after ack updates alarm_ts; a hit while in ALERT does not.
